// File: rtl/host_cmd_framer_pkg.sv
// Shared types and constants for the host command framer: command kinds,
// frame opcodes, frame length lookup and the serial FSM state encoding.
package host_cmd_pkg;

    typedef enum logic [1:0] {
        CMD_RF_WR   = 2'd0,
        CMD_RF_RD   = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_t;

    localparam logic [7:0] OP_RF_WR   = 8'hAA;
    localparam logic [7:0] OP_RF_RD   = 8'hBB;
    localparam logic [7:0] OP_ALU_OP  = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_GAP
    } state_t;

    function automatic logic [2:0] frame_len(input cmd_type_t t);
        case (t)
            CMD_RF_WR:  return 3'd3;
            CMD_RF_RD:  return 3'd2;
            CMD_ALU_OP: return 3'd4;
            default:    return 3'd2;
        endcase
    endfunction

    function automatic logic [7:0] opcode(input cmd_type_t t);
        case (t)
            CMD_RF_WR:  return OP_RF_WR;
            CMD_RF_RD:  return OP_RF_RD;
            CMD_ALU_OP: return OP_ALU_OP;
            default:    return OP_ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/cmd_uart_serializer.sv
// One UART character per byte: start, 8 data bits LSB first, optional parity,
// stop. A new byte may be loaded while idle or in the last stop-bit cycle.
module cmd_uart_serializer
    import host_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_vld,
    input  logic [7:0] byte_in,
    input  logic       byte_last,
    input  logic       par_en,
    input  logic       par_typ,
    input  logic [5:0] prescale,
    output logic       tx,
    output logic       byte_end,
    output logic       done
);

    state_t     state;
    logic [5:0] pq;
    logic [5:0] cnt;
    logic [5:0] pl;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       last_q;
    logic       par_en_q;
    logic       par_bit;
    logic       load;

    // prescale 0 wraps to a reload of 63, i.e. a 64-cycle bit
    assign pl       = pq - 6'd1;
    assign byte_end = (state == ST_STOP) && (cnt == '0);
    assign load     = byte_vld && ((state == ST_IDLE) || byte_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            done     <= 1'b0;
            pq       <= '0;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            last_q   <= 1'b0;
            par_en_q <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                state    <= ST_START;
                tx       <= 1'b0;
                pq       <= prescale;
                cnt      <= prescale - 6'd1;
                bit_cnt  <= '0;
                shreg    <= byte_in;
                last_q   <= byte_last;
                par_en_q <= par_en;
                par_bit  <= (^byte_in) ^ par_typ;
            end else begin
                case (state)
                    ST_START: begin
                        if (cnt == '0) begin
                            state <= ST_DATA;
                            tx    <= shreg[0];
                            cnt   <= pl;
                        end else begin
                            cnt <= cnt - 6'd1;
                        end
                    end
                    ST_DATA: begin
                        if (cnt == '0) begin
                            cnt <= pl;
                            if (bit_cnt == 3'd7) begin
                                if (par_en_q) begin
                                    state <= ST_PARITY;
                                    tx    <= par_bit;
                                end else begin
                                    state <= ST_STOP;
                                    tx    <= 1'b1;
                                    done  <= last_q && (pl == '0);
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shreg   <= {1'b0, shreg[7:1]};
                                tx      <= shreg[1];
                            end
                        end else begin
                            cnt <= cnt - 6'd1;
                        end
                    end
                    ST_PARITY: begin
                        if (cnt == '0) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                            cnt   <= pl;
                            done  <= last_q && (pl == '0);
                        end else begin
                            cnt <= cnt - 6'd1;
                        end
                    end
                    ST_STOP: begin
                        // done is raised on entry to the final stop-bit cycle
                        if (cnt == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt  <= cnt - 6'd1;
                            done <= last_q && (cnt == 6'd1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/host_cmd_framer.sv
// Host command framer: accepts a command, expands it into opcode + operand
// bytes and feeds them to the UART serializer with optional inter-byte gaps.
module host_cmd_framer
    import host_cmd_pkg::*;
#(
    parameter int unsigned GAP_BITS = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CMD_VLD,
    output logic       CMD_RDY,
    input  logic [1:0] CMD_TYPE,
    input  logic [3:0] CMD_ADDR,
    input  logic [7:0] CMD_DATA_A,
    input  logic [7:0] CMD_DATA_B,
    input  logic [3:0] CMD_FUN,
    input  logic [5:0] PRESCALE,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic       TX_OUT,
    output logic       BUSY,
    output logic       FRAME_DONE
);

    state_t     state;
    cmd_type_t  type_q;
    logic [3:0] addr_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [3:0] fun_q;
    logic [5:0] prescale_q;
    logic       par_en_q;
    logic       par_typ_q;
    logic [2:0] idx;
    logic [2:0] n_q;
    logic [31:0] gap_cnt;
    logic [31:0] gap_len;
    logic [6:0] p_eff;
    logic       accept;

    logic       ser_vld;
    logic [7:0] ser_byte;
    logic       ser_last;
    logic [5:0] ser_presc;
    logic       ser_par_en;
    logic       ser_par_typ;
    logic       ser_byte_end;

    function automatic logic [7:0] frame_byte(input cmd_type_t t, input logic [2:0] i,
                                              input logic [3:0] addr, input logic [7:0] op_a,
                                              input logic [7:0] op_b, input logic [3:0] fun);
        logic [7:0] v;
        v = opcode(t);
        case (t)
            CMD_RF_WR: begin
                if (i == 3'd1) v = {4'h0, addr};
                else if (i == 3'd2) v = op_a;
            end
            CMD_RF_RD: begin
                if (i == 3'd1) v = {4'h0, addr};
            end
            CMD_ALU_OP: begin
                if (i == 3'd1) v = op_a;
                else if (i == 3'd2) v = op_b;
                else if (i == 3'd3) v = {4'h0, fun};
            end
            default: begin
                if (i == 3'd1) v = {4'h0, fun};
            end
        endcase
        return v;
    endfunction

    assign CMD_RDY = (state == ST_IDLE) && !RST;
    assign BUSY    = (state != ST_IDLE) && !RST;
    assign accept  = CMD_VLD && CMD_RDY;
    assign n_q     = frame_len(type_q);
    assign p_eff   = (prescale_q == '0) ? 7'd64 : {1'b0, prescale_q};
    assign gap_len = 32'(GAP_BITS) * 32'(p_eff);

    // The opcode byte goes out on the accept edge itself, straight from the inputs
    always_comb begin
        ser_vld     = 1'b0;
        ser_byte    = opcode(cmd_type_t'(CMD_TYPE));
        ser_last    = 1'b0;
        ser_presc   = prescale_q;
        ser_par_en  = par_en_q;
        ser_par_typ = par_typ_q;
        if (state == ST_IDLE) begin
            ser_vld     = accept;
            ser_presc   = PRESCALE;
            ser_par_en  = PAR_EN;
            ser_par_typ = PAR_TYP;
        end else begin
            ser_byte = frame_byte(type_q, idx, addr_q, a_q, b_q, fun_q);
            ser_last = (idx == n_q - 3'd1);
            if (state == ST_GAP)
                ser_vld = (gap_cnt == '0);
            else if (GAP_BITS == 0)
                ser_vld = ser_byte_end && (idx != n_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            type_q     <= CMD_RF_WR;
            addr_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            fun_q      <= '0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            idx        <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        type_q     <= cmd_type_t'(CMD_TYPE);
                        addr_q     <= CMD_ADDR;
                        a_q        <= CMD_DATA_A;
                        b_q        <= CMD_DATA_B;
                        fun_q      <= CMD_FUN;
                        prescale_q <= PRESCALE;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        idx        <= 3'd1;
                        state      <= ST_DATA;
                    end
                end
                // DATA here means a character is on the line; the serializer owns its bit phases
                ST_DATA: begin
                    if (ser_byte_end) begin
                        if (idx == n_q) begin
                            state <= ST_IDLE;
                        end else if (GAP_BITS == 0) begin
                            idx <= idx + 3'd1;
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= gap_len - 32'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        idx   <= idx + 3'd1;
                        state <= ST_DATA;
                    end else begin
                        gap_cnt <= gap_cnt - 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    cmd_uart_serializer u_ser (
        .clk       (CLK),
        .rst       (RST),
        .byte_vld  (ser_vld),
        .byte_in   (ser_byte),
        .byte_last (ser_last),
        .par_en    (ser_par_en),
        .par_typ   (ser_par_typ),
        .prescale  (ser_presc),
        .tx        (TX_OUT),
        .byte_end  (ser_byte_end),
        .done      (FRAME_DONE)
    );

endmodule

// File: tb/tb_host_cmd_framer.sv
// Bench for host_cmd_framer: two instances (GAP_BITS=1 and 0) compared cycle by
// cycle against a waveform model built from the frame and character rules.
module tb_host_cmd_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld1, vld0;
    logic [1:0] ctype;
    logic [3:0] caddr;
    logic [7:0] ca, cb;
    logic [3:0] cfun;
    logic [5:0] cps;
    logic       cpe, cpt;
    logic       rdy1, tx1, busy1, done1;
    logic       rdy0, tx0, busy0, done0;

    int tests  = 0;
    int failed = 0;

    bit etx1[$], erdy1[$], edone1[$];
    bit etx0[$], erdy0[$], edone0[$];
    bit act1, act0;
    int nx_ty, nx_addr, nx_a, nx_b, nx_fun, nx_ps, nx_pe, nx_pt;

    always #5 clk = ~clk;

    host_cmd_framer #(.GAP_BITS(1)) dut1 (
        .CLK(clk), .RST(rst), .CMD_VLD(vld1), .CMD_RDY(rdy1), .CMD_TYPE(ctype),
        .CMD_ADDR(caddr), .CMD_DATA_A(ca), .CMD_DATA_B(cb), .CMD_FUN(cfun),
        .PRESCALE(cps), .PAR_EN(cpe), .PAR_TYP(cpt), .TX_OUT(tx1), .BUSY(busy1),
        .FRAME_DONE(done1)
    );

    host_cmd_framer #(.GAP_BITS(0)) dut0 (
        .CLK(clk), .RST(rst), .CMD_VLD(vld0), .CMD_RDY(rdy0), .CMD_TYPE(ctype),
        .CMD_ADDR(caddr), .CMD_DATA_A(ca), .CMD_DATA_B(cb), .CMD_FUN(cfun),
        .PRESCALE(cps), .PAR_EN(cpe), .PAR_TYP(cpt), .TX_OUT(tx0), .BUSY(busy0),
        .FRAME_DONE(done0)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input int ty);
        return (ty == 0) ? 3 : (ty == 1) ? 2 : (ty == 2) ? 4 : 2;
    endfunction

    function automatic int fbyte(input int ty, input int i, input int addr,
                                 input int a, input int b, input int fun);
        int fr[4];
        case (ty)
            0:       fr = '{170, addr, a, 0};
            1:       fr = '{187, addr, 0, 0};
            2:       fr = '{204, a, b, fun};
            default: fr = '{221, fun, 0, 0};
        endcase
        return fr[i];
    endfunction

    task automatic push(input int d, input bit t, input bit r, input bit dn);
        if (d == 1) begin etx1.push_back(t); erdy1.push_back(r); edone1.push_back(dn); end
        else        begin etx0.push_back(t); erdy0.push_back(r); edone0.push_back(dn); end
    endtask

    task automatic add_idle(input int d, input int k);
        for (int i = 0; i < k; i++) push(d, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic add_frame(input int d, input int gap, input int ty, input int addr,
                             input int a, input int b, input int fun,
                             input int ps, input int pe, input int pt);
        int p, n, nb;
        bit bits[11];
        logic [7:0] bv;
        p  = (ps == 0) ? 64 : ps;
        n  = nbytes(ty);
        nb = pe ? 11 : 10;
        for (int i = 0; i < n; i++) begin
            if (i > 0) for (int c = 0; c < gap * p; c++) push(d, 1'b1, 1'b0, 1'b0);
            bv = 8'(fbyte(ty, i, addr, a, b, fun));
            bits[0] = 1'b0;
            for (int j = 0; j < 8; j++) bits[j + 1] = bv[j];
            if (pe != 0) bits[9] = 1'(($countones(bv) & 1) ^ pt);
            bits[nb - 1] = 1'b1;
            for (int k = 0; k < nb; k++)
                for (int c = 0; c < p; c++)
                    push(d, bits[k], 1'b0, (i == n - 1) && (k == nb - 1) && (c == p - 1));
        end
    endtask

    task automatic clear_model();
        etx1.delete(); erdy1.delete(); edone1.delete();
        etx0.delete(); erdy0.delete(); edone0.delete();
    endtask

    task automatic pad_model();
        while (etx0.size() < etx1.size()) add_idle(0, 1);
        while (etx1.size() < etx0.size()) add_idle(1, 1);
    endtask

    task automatic scramble();
        ctype = 2'($urandom); caddr = 4'($urandom); ca = 8'($urandom); cb = 8'($urandom);
        cfun = 4'($urandom); cps = 6'($urandom); cpe = 1'($urandom); cpt = 1'($urandom);
    endtask

    task automatic drive(input int ty, input int addr, input int a, input int b,
                         input int fun, input int ps, input int pe, input int pt);
        ctype = 2'(ty); caddr = 4'(addr); ca = 8'(a); cb = 8'(b);
        cfun = 4'(fun); cps = 6'(ps); cpe = 1'(pe); cpt = 1'(pt);
    endtask

    // Called at a negedge with both DUTs idle; acceptance is the following posedge.
    task automatic start_cmd(input int ty, input int addr, input int a, input int b,
                             input int fun, input int ps, input int pe, input int pt,
                             input bit en1, input bit en0);
        if (en1) check("rdy_before_g1", rdy1, 1);
        if (en0) check("rdy_before_g0", rdy0, 1);
        drive(ty, addr, a, b, fun, ps, pe, pt);
        vld1 = en1;
        vld0 = en0;
        act1 = en1;
        act0 = en0;
    endtask

    task automatic run(input string tag, input int len, input int swap_idx, input int drop_idx);
        int mtx1 = 0, mrdy1 = 0, mbusy1 = 0, mdone1 = 0;
        int mtx0 = 0, mrdy0 = 0, mbusy0 = 0, mdone0 = 0;
        @(posedge clk);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (act1 && k < etx1.size()) begin
                if (tx1 !== etx1[k]) mtx1++;
                if (rdy1 !== erdy1[k]) mrdy1++;
                if (busy1 !== !erdy1[k]) mbusy1++;
                if (done1 !== edone1[k]) mdone1++;
            end
            if (act0 && k < etx0.size()) begin
                if (tx0 !== etx0[k]) mtx0++;
                if (rdy0 !== erdy0[k]) mrdy0++;
                if (busy0 !== !erdy0[k]) mbusy0++;
                if (done0 !== edone0[k]) mdone0++;
            end
            if (k == swap_idx) drive(nx_ty, nx_addr, nx_a, nx_b, nx_fun, nx_ps, nx_pe, nx_pt);
            if (k == drop_idx) begin
                vld1 = 1'b0;
                vld0 = 1'b0;
                scramble();
            end
        end
        if (act1) begin
            check({tag, "_tx_g1"}, mtx1, 0);
            check({tag, "_rdy_g1"}, mrdy1, 0);
            check({tag, "_busy_g1"}, mbusy1, 0);
            check({tag, "_done_g1"}, mdone1, 0);
        end
        if (act0) begin
            check({tag, "_tx_g0"}, mtx0, 0);
            check({tag, "_rdy_g0"}, mrdy0, 0);
            check({tag, "_busy_g0"}, mbusy0, 0);
            check({tag, "_done_g0"}, mdone0, 0);
        end
    endtask

    task automatic single(input string tag, input int ty, input int addr, input int a,
                          input int b, input int fun, input int ps, input int pe, input int pt);
        clear_model();
        add_frame(1, 1, ty, addr, a, b, fun, ps, pe, pt);
        add_idle(1, 2);
        add_frame(0, 0, ty, addr, a, b, fun, ps, pe, pt);
        add_idle(0, 2);
        pad_model();
        start_cmd(ty, addr, a, b, fun, ps, pe, pt, 1'b1, 1'b1);
        run(tag, etx1.size(), -1, 0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t1, pick, ps;
        int ndone, nbad;
        rst = 1'b1;
        vld1 = 1'b0;
        vld0 = 1'b0;
        drive(0, 0, 0, 0, 0, 8, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_tx", tx1, 1);
        check("rst_rdy", rdy1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_rdy_g0", rdy0, 0);
        rst = 1'b0;
        @(negedge clk);

        single("rfwr", 0, 4, 8'h5A, 0, 0, 8, 0, 0);
        single("aluop", 2, 0, 8'h12, 8'h34, 0, 16, 1, 0);
        single("rfrd", 1, 4'hA, 0, 0, 0, 32, 1, 1);

        // back-to-back with CMD_VLD held; second command presented mid-frame
        clear_model();
        add_frame(1, 1, 3, 0, 0, 0, 3, 8, 0, 0);
        t1 = etx1.size();
        add_idle(1, 1);
        add_frame(1, 1, 3, 0, 0, 0, 8, 8, 0, 0);
        add_idle(1, 2);
        nx_ty = 3; nx_addr = 9; nx_a = 8'h77; nx_b = 8'h11; nx_fun = 8; nx_ps = 8; nx_pe = 0; nx_pt = 0;
        start_cmd(3, 2, 8'h33, 8'h44, 3, 8, 0, 0, 1'b1, 1'b0);
        run("b2b", etx1.size(), 0, t1 + 1);

        // reset mid-DATA of the second byte (address 0 keeps the line low there)
        clear_model();
        add_frame(1, 1, 0, 0, 8'hC3, 0, 0, 8, 0, 0);
        start_cmd(0, 0, 8'hC3, 0, 0, 8, 0, 0, 1'b1, 1'b0);
        run("pre_rst", 120, -1, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", tx1, 1);
        check("midrst_rdy", rdy1, 0);
        check("midrst_busy", busy1, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", rdy1, 1);
        ndone = 0;
        nbad = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done1 !== 1'b0) ndone++;
            if (tx1 !== 1'b1 || rdy1 !== 1'b1) nbad++;
        end
        check("post_rst_no_done", ndone, 0);
        check("post_rst_idle", nbad, 0);
        single("rfrd_after_rst", 1, 4'h6, 0, 0, 0, 8, 0, 0);

        single("p64", 3, 0, 0, 0, 4'h5, 0, 1, 1);

        for (int r = 0; r < 6; r++) begin
            pick = int'($urandom_range(0, 4));
            ps = (pick == 0) ? 0 : (pick == 1) ? 8 : (pick == 2) ? 16 :
                 (pick == 3) ? 32 : int'($urandom_range(1, 63));
            single("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 15)), ps, int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
